// File: rtl/pixel_mem_stage_if.sv
// Host load/readout port of pixel_mem_stage: request channel plus registered read return.
interface pixel_mem_stage_if #(
    parameter int DW = 18,
    parameter int AW = 10
);
    logic          host_valid;
    logic          host_ready;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;

    modport master (
        output host_valid, host_we, host_addr, host_wdata,
        input  host_ready, host_rdata, host_rvalid
    );

    modport slave (
        input  host_valid, host_we, host_addr, host_wdata,
        output host_ready, host_rdata, host_rvalid
    );
endinterface

// File: rtl/pixel_mem_stage.sv
// Memory stage: three-lane combinational read / store, host port and array clear sequencer.
// Define BORDER_CLAMP_EN to replicate border pixels on lanes 1/2 instead of wrapping.
module pixel_mem_stage #(
    parameter int DW    = 18,
    parameter int AW    = 10,
    parameter int DEPTH = 1024
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [AW-1:0]      A1M,
    input  logic [AW-1:0]      A2M,
    input  logic [AW-1:0]      A3M,
    input  logic [2:0][DW-1:0] writeDataM,
    input  logic               MemWriteM,
    output logic [2:0][DW-1:0] RDM,
    output logic               StallMem,
    input  logic               clear_start,
    output logic               clear_done,
    pixel_mem_stage_if.slave   host
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t             state;
    logic [AW-1:0]      counter;
    logic [DW-1:0]      mem [DEPTH];
    logic [2:0][AW-1:0] eff;
    logic [2:0]         lane_ok;
    logic               pipe_we;
    logic               host_ok;
    logic               host_acc;

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    always_comb begin
        eff[0] = A1M;
`ifdef BORDER_CLAMP_EN
        eff[1] = (A1M == LAST && A2M > LAST) ? LAST : A2M;
        eff[2] = (A1M == '0) ? '0 : A3M;
`else
        eff[1] = A2M;
        eff[2] = A3M;
`endif
        lane_ok = '0;
        RDM     = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            lane_ok[i] = in_range(eff[i]);
            RDM[i]     = lane_ok[i] ? mem[eff[i]] : '0;
        end
    end

    assign StallMem        = (state == CLEAR);
    assign pipe_we         = MemWriteM && (state == IDLE);
    assign host.host_ready = (state == IDLE) && !(host.host_we && MemWriteM);
    assign host_ok         = in_range(host.host_addr);
    assign host_acc        = host.host_valid && host.host_ready;

    // Lanes are applied 2,1,0 so the lowest lane's write is the one that sticks on aliasing.
    always_ff @(posedge CLK) begin
        if (state == CLEAR) begin
            mem[counter] <= '0;
        end else begin
            for (int unsigned k = 0; k < 3; k++) begin
                if (pipe_we && lane_ok[2-k])
                    mem[eff[2-k]] <= writeDataM[2-k];
            end
            if (host_acc && host.host_we && host_ok)
                mem[host.host_addr] <= host.host_wdata;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state            <= IDLE;
            counter          <= '0;
            clear_done       <= 1'b0;
            host.host_rdata  <= '0;
            host.host_rvalid <= 1'b0;
        end else begin
            clear_done       <= 1'b0;
            host.host_rvalid <= host_acc && !host.host_we;
            if (host_acc && !host.host_we)
                host.host_rdata <= host_ok ? mem[host.host_addr] : '0;
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        state   <= CLEAR;
                        counter <= '0;
                    end
                end
                CLEAR: begin
                    counter <= counter + 1'b1;
                    if (counter == LAST) begin
                        state      <= IDLE;
                        clear_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_mem_stage.sv
// Bench for pixel_mem_stage: directed sequences, a vector table and randomized traffic
// checked every cycle against a word-array reference model.
module tb_pixel_mem_stage;
    localparam int DW    = 18;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;

`ifdef BORDER_CLAMP_EN
    localparam logic [DW-1:0] L2_LO = 18'd7;
`else
    localparam logic [DW-1:0] L2_LO = 18'd9;
`endif

    logic               CLK, RST;
    logic [AW-1:0]      a1, a2, a3;
    logic [2:0][DW-1:0] wdata, rdm;
    logic               mwe, stall, cstart, cdone;

    pixel_mem_stage_if #(.DW(DW), .AW(AW)) hif ();

    pixel_mem_stage #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST),
        .A1M(a1), .A2M(a2), .A3M(a3),
        .writeDataM(wdata), .MemWriteM(mwe), .RDM(rdm),
        .StallMem(stall), .clear_start(cstart), .clear_done(cdone),
        .host(hif.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_tests, n_fail;

    // reference model
    logic [DW-1:0] mm [DEPTH];
    bit            kn [DEPTH];
    int            stall_left, zero_ptr;
    bit            exp_rvalid, exp_done, rd_known;
    logic [DW-1:0] exp_rdata;

    typedef struct {
        logic [AW-1:0] a1, a2, a3;
        logic [DW-1:0] e0, e1, e2;
    } vec_t;
    vec_t tbl [4];
    int   wa [5] = '{0, 1, 1023, 1022, 2};
    int   wv [5] = '{7, 8, 9, 6, 5};

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int eff_addr(input int lane);
        int a;
        a = (lane == 0) ? int'(a1) : (lane == 1) ? int'(a2) : int'(a3);
`ifdef BORDER_CLAMP_EN
        if (lane == 1 && int'(a1) == DEPTH - 1 && a > DEPTH - 1) a = DEPTH - 1;
        if (lane == 2 && int'(a1) == 0) a = 0;
`endif
        return a;
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return 10'($urandom_range(0, 15));
        return 10'($urandom_range(1008, 1023));
    endfunction

    // Check the current cycle's combinational outputs, advance the model one clock,
    // then check the registered outputs just after the edge.
    task automatic step();
        bit idle, ready, acc;
        int e;
        #1;
        idle  = (stall_left == 0);
        ready = idle && !(hif.host_we && mwe);
        check("stall", stall, !idle);
        check("host_ready", hif.host_ready, ready);
        for (int l = 0; l < 3; l++) begin
            e = eff_addr(l);
            if (kn[e]) check($sformatf("rdm%0d", l), rdm[l], mm[e]);
        end
        acc        = hif.host_valid && ready;
        exp_rvalid = acc && !hif.host_we;
        if (exp_rvalid) begin
            rd_known  = kn[hif.host_addr];
            exp_rdata = mm[hif.host_addr];
        end
        exp_done = 1'b0;
        if (!idle) begin
            mm[zero_ptr] = '0;
            kn[zero_ptr] = 1'b1;
            zero_ptr++;
            stall_left--;
            exp_done = (stall_left == 0);
        end else begin
            if (mwe) begin
                for (int l = 2; l >= 0; l--) begin
                    e     = eff_addr(l);
                    mm[e] = wdata[l];
                    kn[e] = 1'b1;
                end
            end
            if (acc && hif.host_we) begin
                mm[hif.host_addr] = hif.host_wdata;
                kn[hif.host_addr] = 1'b1;
            end
            if (cstart) begin
                stall_left = DEPTH;
                zero_ptr   = 0;
            end
        end
        @(posedge CLK);
        #1;
        check("host_rvalid", hif.host_rvalid, exp_rvalid);
        if (exp_rvalid && rd_known) check("host_rdata", hif.host_rdata, exp_rdata);
        check("clear_done", cdone, exp_done);
    endtask

    task automatic pulse_reset();
        RST = 1'b0;
        #1;
        check("rst_mid_stall", stall, 0);
        check("rst_mid_done", cdone, 0);
        check("rst_mid_ready", hif.host_ready, 1);
        check("rst_mid_rdata", hif.host_rdata, 0);
        check("rst_mid_rvalid", hif.host_rvalid, 0);
        stall_left = 0;
        exp_rvalid = 1'b0;
        exp_done   = 1'b0;
        #1 RST = 1'b1;
    endtask

    // Call right after the step that sampled clear_start.
    task automatic run_clear(input string tag, input bit with_store);
        int stalls, dones;
        stalls = 0;
        dones  = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            mwe = with_store && (i >= 10) && (i < DEPTH - 1);
            if (stall) stalls++;
            if (cdone) dones++;
            step();
        end
        mwe = 1'b0;
        check({tag, "_stall_cycles"}, stalls, DEPTH);
        check({tag, "_done_pulses"}, dones, 1);
    endtask

    task automatic idle_inputs();
        mwe = 1'b0; cstart = 1'b0;
        hif.host_valid = 1'b0; hif.host_we = 1'b0;
    endtask

    initial begin
        int bad;
        n_tests = 0; n_fail = 0;
        stall_left = 0; zero_ptr = 0;
        exp_rvalid = 1'b0; exp_done = 1'b0; rd_known = 1'b0; exp_rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin mm[i] = '0; kn[i] = 1'b0; end
        tbl[0] = '{10'd0,    10'd1, 10'd1023, 18'd7, 18'd8, L2_LO};
        tbl[1] = '{10'd1023, 10'd0, 10'd1022, 18'd9, 18'd7, 18'd6};
        tbl[2] = '{10'd1,    10'd2, 10'd0,    18'd8, 18'd5, 18'd7};
        tbl[3] = '{10'd0,    10'd0, 10'd0,    18'd7, 18'd7, 18'd7};

        RST = 1'b0;
        a1 = '0; a2 = '0; a3 = '0; wdata = '0;
        hif.host_addr = '0; hif.host_wdata = '0;
        idle_inputs();
        repeat (3) @(posedge CLK);
        #1;
        check("reset_stall", stall, 0);
        check("reset_done", cdone, 0);
        check("reset_ready", hif.host_ready, 1);
        check("reset_rdata", hif.host_rdata, 0);
        check("reset_rvalid", hif.host_rvalid, 0);
        RST = 1'b1;

        // initial sweep, with pipeline stores to word 3 attempted mid-sweep
        a1 = 10'd3; a2 = 10'd3; a3 = 10'd3; wdata = '1;
        cstart = 1'b1; step(); cstart = 1'b0;
        run_clear("clear0", 1'b1);
        #1 check("sweep_store_ignored", rdm[0], 0);

        // host write then read of word 5
        hif.host_valid = 1'b1; hif.host_we = 1'b1;
        hif.host_addr = 10'd5; hif.host_wdata = 18'h155AA;
        step();
        hif.host_we = 1'b0;
        step();
        check("host_rd_latency", hif.host_rvalid, 1);
        check("host_rd_data", hif.host_rdata, 18'h155AA);
        hif.host_valid = 1'b0;
        step();
        check("host_rvalid_single", hif.host_rvalid, 0);

        // pipeline store; old values during the store cycle, new values after
        a1 = 10'd10; a2 = 10'd11; a3 = 10'd9;
        wdata[0] = 18'd1; wdata[1] = 18'd2; wdata[2] = 18'd3;
        mwe = 1'b1;
        #1;
        check("store_cycle_old0", rdm[0], 0);
        check("store_cycle_old2", rdm[2], 0);
        step();
        mwe = 1'b0;
        #1;
        check("store_new0", rdm[0], 1);
        check("store_new1", rdm[1], 2);
        check("store_new2", rdm[2], 3);
        step();

        // host write blocked by a pipeline store
        hif.host_valid = 1'b1; hif.host_we = 1'b1;
        hif.host_addr = 10'd20; hif.host_wdata = 18'h2AAAA;
        a1 = 10'd20; a2 = 10'd21; a3 = 10'd19;
        wdata[0] = 18'h11111; wdata[1] = 18'h22; wdata[2] = 18'h33;
        mwe = 1'b1;
        #1 check("conflict_ready_low", hif.host_ready, 0);
        step();
        #1 check("conflict_ready_low2", hif.host_ready, 0);
        step();
        mwe = 1'b0;
        #1;
        check("conflict_ready_high", hif.host_ready, 1);
        check("conflict_pipe_landed", rdm[0], 18'h11111);
        step();
        hif.host_valid = 1'b0;
        #1 check("conflict_host_landed", rdm[0], 18'h2AAAA);
        step();

        // aliased lanes: lane 0 wins
        a1 = 10'd30; a2 = 10'd30; a3 = 10'd30;
        wdata[0] = 18'h100; wdata[1] = 18'h200; wdata[2] = 18'h300;
        mwe = 1'b1; step(); mwe = 1'b0;
        #1 check("alias_lane0_wins", rdm[1], 18'h100);
        step();

        // border vectors
        for (int i = 0; i < 5; i++) begin
            hif.host_valid = 1'b1; hif.host_we = 1'b1;
            hif.host_addr = 10'(wa[i]); hif.host_wdata = 18'(wv[i]);
            step();
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            a1 = tbl[i].a1; a2 = tbl[i].a2; a3 = tbl[i].a3;
            #1;
            check($sformatf("vec%0d_l0", i), rdm[0], tbl[i].e0);
            check($sformatf("vec%0d_l1", i), rdm[1], tbl[i].e1);
            check($sformatf("vec%0d_l2", i), rdm[2], tbl[i].e2);
            step();
        end

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            a1 = rnd_addr(); a2 = rnd_addr(); a3 = rnd_addr();
            for (int l = 0; l < 3; l++) wdata[l] = 18'($urandom);
            mwe            = ($urandom_range(0, 3) == 0);
            hif.host_valid = ($urandom_range(0, 1) == 1);
            hif.host_we    = ($urandom_range(0, 2) == 0);
            hif.host_addr  = rnd_addr();
            hif.host_wdata = 18'($urandom);
            cstart         = ($urandom_range(0, 999) == 0);
            step();
        end
        idle_inputs();
        for (int i = 0; i < DEPTH + 2 && stall_left > 0; i++) step();

        // fill, start a sweep, reset it at counter 500
        for (int i = 0; i < DEPTH; i++) begin
            hif.host_valid = 1'b1; hif.host_we = 1'b1;
            hif.host_addr = 10'(i); hif.host_wdata = 18'(i + 100);
            step();
        end
        idle_inputs();
        cstart = 1'b1; step(); cstart = 1'b0;
        repeat (500) step();
        pulse_reset();
        a1 = 10'd499; a2 = 10'd500; a3 = 10'd1023;
        #1;
        check("rst_word499_zero", rdm[0], 0);
        check("rst_word500_kept", rdm[1], 600);
        check("rst_word1023_kept", rdm[2], 1123);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (cdone || stall) bad++;
            step();
        end
        check("rst_no_done_no_stall", bad, 0);

        // host read and clear_start on the same edge, then a full sweep
        hif.host_valid = 1'b1; hif.host_we = 1'b0; hif.host_addr = 10'd1000;
        cstart = 1'b1; step(); cstart = 1'b0;
        hif.host_valid = 1'b0;
        check("clear_host_same_rvalid", hif.host_rvalid, 1);
        check("clear_host_same_rdata", hif.host_rdata, 1100);
        run_clear("clear1", 1'b0);
        bad = 0;
        for (int k = 0; k < DEPTH; k += 3) begin
            a1 = 10'(k); a2 = 10'(k + 1); a3 = 10'(k + 2);
            #1;
            for (int l = 0; l < 3; l++) if (rdm[l] !== '0) bad++;
            step();
        end
        check("clear_all_zero", bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pixel_mem_stage.md
# pixel_mem_stage

Memory-stage block for the filter GPU pipeline. It consumes the M-stage outputs of the datapath (three neighbouring pixel addresses, three-lane 18-bit store data, store enable) and returns the three-lane read data that the writeback buffer captures. It also provides a host load/readout port for image transfer and a memory-clear sequencer that stalls the pipeline while it sweeps the array.

## Interface
Parameters:
- DW, 18, lane/word width in bits
- AW, 10, address width
- DEPTH, 1024, number of words; must be ≤ 2^AW

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous, active-low reset
- A1M  in  AW  lane 0 address (centre pixel)
- A2M  in  AW  lane 1 address (centre+1)
- A3M  in  AW  lane 2 address (centre−1)
- writeDataM  in  3×DW  store data; [0]→A1M, [1]→A2M, [2]→A3M
- MemWriteM  in  1  pipeline store enable
- RDM  out  3×DW  read data, lane i from lane i's effective address
- StallMem  out  1  high while the clear sequence owns the array
- clear_start  in  1  single-cycle request to zero the array
- clear_done  out  1  one-cycle pulse after the last clear write
- host_valid  in  1  host request valid
- host_ready  out  1  host request may be accepted this cycle
- host_we  in  1  1 = write, 0 = read
- host_addr  in  AW  host word address
- host_wdata  in  DW  host write data
- host_rdata  out  DW  registered host read data
- host_rvalid  out  1  one-cycle pulse, host_rdata valid

## Operation
- Array: DEPTH×DW words, no reset of contents.
- Pipeline read: combinational; RDM[i] = mem[eff_addr_i] in the same cycle.
- Effective addresses: lane 0 uses A1M unchanged; lanes 1/2 are handled per the Configuration section.
- Pipeline write: with MemWriteM=1 and FSM in IDLE, all three lanes are written at the rising edge. When lanes alias the same address, the lowest lane index wins (lane 0 > lane 1 > lane 2).
- Addresses ≥ DEPTH: the write is dropped for that lane; the read returns 0.
- Host accept: host_valid & host_ready.
  - host_ready = (state==IDLE) & ~(host_we & MemWriteM).
  - A host write conflicting with a pipeline store waits; the pipeline always has priority.
  - Host reads never conflict.
- Host write: mem[host_addr] ← host_wdata at the accepting edge. The pipeline never writes in the same cycle, because ready is low in that case.
- Host read: host_rdata ← mem[host_addr] at the accepting edge. This is the pre-write value if a pipeline store hits the same word that cycle. host_rvalid pulses during the following cycle.
- Clear FSM, states IDLE and CLEAR:
  - IDLE → CLEAR on clear_start; counter ← 0.
  - In CLEAR: mem[counter] ← 0 and counter++ each cycle. At counter = DEPTH−1, the write completes and the FSM returns to IDLE with clear_done=1 for one cycle.
  - clear_start while in CLEAR is ignored.
  - In CLEAR: StallMem=1, host_ready=0, MemWriteM ignored, RDM continues to reflect current contents.

## Timing
- Reset values: StallMem=0, clear_done=0, host_ready=1 (per formula, IDLE), host_rdata=0, host_rvalid=0; FSM=IDLE; counter=0.
- Reset mid-clear: the FSM returns to IDLE immediately, already-zeroed words stay zero, and no clear_done is generated.
- Pipeline read latency: 0 cycles; a stored value is visible on RDM from the cycle after the write edge.
- Host read latency: 1 cycle (accept edge → host_rvalid high the next cycle). Back-to-back accepted reads produce back-to-back rvalid pulses.
- Clear:
  - clear_start sampled at edge T.
  - StallMem is high from T+ through the cycle of the write to DEPTH−1, i.e. DEPTH cycles.
  - clear_done is high in the cycle after that write; StallMem is low in that cycle.
- A host request and clear_start in the same cycle (FSM in IDLE): the host request is accepted and the clear starts at the same edge.

## Configuration
- BORDER_CLAMP_EN defined:
  - Lane 1 address = min(A2M, DEPTH−1) when A1M = DEPTH−1, else A2M.
  - Lane 2 address = 0 when A1M = 0, else A3M.
  - This replicates border pixels instead of wrapping.
- Undefined: lanes 1/2 use A2M/A3M unmodified, wrapping modulo 2^AW (A1M=0 → lane 2 reads 1023).

## Test plan
- Host write 0x155AA to addr 5, then host read addr 5 → host_rvalid one cycle after accept, host_rdata=0x155AA.
- Pipeline store with A1M=10, A2M=11, A3M=9, data {3,2,1} → next cycle RDM with the same addresses = {3,2,1}; read in the store cycle returns old values.
- Host write with MemWriteM=1 in the same cycle → host_ready=0 until MemWriteM drops; the pipeline data lands, then the host data lands.
- A1M=0, A3M=1023 with mem[0]=7, mem[1023]=9 → RDM[2]=7 with BORDER_CLAMP_EN, 9 without.
- clear_start after filling memory → StallMem high exactly DEPTH cycles, clear_done single pulse, all words read 0, MemWriteM during the sweep has no effect.
- Reset asserted at clear counter 500 → outputs at reset values immediately, words 0..499 zero, 500+ unchanged, no clear_done.
